camera_capture_window: RTL and testbench
========================================

Name: camera_capture_window

Overview:
- Parametrised DVP camera capture front-end; successor to the fixed 640x480 RGB565 camera reader.
- Samples vsync/href/data in the camera pixel-clock domain and assembles multi-byte pixels.
- Tracks row and column, applies a runtime crop window and power-of-two decimation.
- Buffers accepted pixels in a small FIFO with valid/ready and SOF/EOL sideband, feeding the SDRAM write-FIFO.

Parameters:
- DATA_W, 8, camera bus width per byte beat
- BPP, 2, byte beats per pixel (1..4); pixel width PIX_W = DATA_W*BPP
- COL_W, 11, column counter / window coordinate width
- ROW_W, 10, row counter width
- FIFO_DEPTH, 16, output buffer entries (power of two, >=4)
- DEC_W, 2, width of decimation exponent

Ports:
- i_clk  in  1  camera pixel clock
- i_rst_n  in  1  asynchronous active-low reset
- i_enable  in  1  capture enable; sampled at frame boundary only
- i_vsync  in  1  camera vsync, active-high
- i_href  in  1  camera href, active-high
- i_data  in  DATA_W  camera data byte
- i_win_x0  in  COL_W  window first column
- i_win_y0  in  ROW_W  window first row
- i_win_w  in  COL_W  window width in source pixels (0 = empty window)
- i_win_h  in  ROW_W  window height in source rows
- i_decim_log2  in  DEC_W  keep 1 of 2^n pixels in both axes
- i_clr_status  in  1  clears sticky overflow
- o_valid  out  1  pixel available
- o_data  out  PIX_W  pixel, first byte in MSBs
- o_sof  out  1  first pixel of frame, qualified by o_valid
- o_eol  out  1  last kept pixel of a line, qualified by o_valid
- i_ready  in  1  downstream accept
- o_row_max  out  ROW_W  rows counted in previous frame
- o_col_max  out  COL_W  pixels in last completed line
- o_frame_cnt  out  8  completed frames, wraps at 255
- o_overflow  out  1  sticky: pixel dropped because FIFO full

Behaviour:
- Reset: all outputs 0, FIFO empty, state DISARMED.
- Input stage: vsync/href/data registered once; edges are detected on the registered copies.
- States:
  - DISARMED: ignore data; on vsync rise go to SYNC_WAIT.
  - SYNC_WAIT: on vsync fall go to CAPTURE if the latched enable is 1, else stay in SYNC_WAIT.
  - CAPTURE: on vsync rise, end the frame and go back to SYNC_WAIT.
- Vsync rise, in any state except DISARMED:
  - row_max <= row; frame_cnt++ (only if leaving CAPTURE).
  - row/col/byte-phase cleared; SOF-pending set.
  - Window, decimation and enable copied into shadow registers; mid-frame input changes have no effect.
- CAPTURE, href high: byte phase counts 0..BPP-1, shifting bytes in MSB-first. At phase BPP-1 the pixel completes at the current col, then col++. col saturates at all-ones and never wraps.
- Href fall:
  - Partial pixel is discarded and byte phase cleared.
  - If col != 0: col_max <= col, row++ (saturating), col <= 0.
- Keep rule: x0 <= col < x0+w, y0 <= row < y0+h, and the low n bits of (col-x0) and (row-y0) are zero. Sums are computed COL_W+1 / ROW_W+1 bits wide, with no wrap. w=0 or h=0 means nothing is kept.
- EOL is set on a kept pixel when col + 2^n >= x0+w. SOF is set on the first kept pixel after vsync, then SOF-pending clears.
- Latency: a kept pixel is written to the FIFO 2 cycles after its last byte appears on the pins. o_valid asserts the following cycle if the FIFO was empty (3 cycles total).
- FIFO handshake:
  - Transfer occurs when o_valid & i_ready.
  - o_data, o_sof and o_eol hold stable while o_valid & !i_ready.
  - A push when full is accepted only if a pop occurs in the same cycle; otherwise the pixel is dropped and o_overflow is set.
  - Push and pop together on empty: the pixel appears next cycle.
- o_overflow clears on i_clr_status. If both events occur in the same cycle, set wins.
- Vsync rise does not flush the FIFO; queued pixels drain normally.
- Asynchronous reset mid-frame: return to DISARMED. The remainder of that frame is never emitted.

Optional Feature:
- Macro CAPTURE_TESTPATTERN_EN.
- When defined: extra input i_tp_sel (1 bit). When 1, each kept pixel's data is replaced by {row[PIX_W/2-1:0], col[PIX_W/2-1:0]}, zero-extended per field. Timing, keep rule and flags are unchanged.
- When undefined: the port is absent and data is always the camera bytes.

Test Plan:
- Full window, BPP=2: reset, 2 frames of 4 lines x 8 pixels, window (0,0,8,4), n=0, i_ready=1.
  - Expect 32 pixels per frame, MSB-first byte order.
  - SOF on pixel 0; EOL on cols 7; row_max=4, col_max=8, frame_cnt=2 (1 after first full frame).
- Crop plus decimation: window (2,1,4,2), n=1 on 8x4 frames.
  - Expect cols 2,4 of rows 1 only (row 2 is odd offset): 2 pixels.
  - EOL on col 4.
- Backpressure: i_ready=0 for a 20-pixel line with FIFO_DEPTH=16.
  - Expect the first 16 pixels retained in order, 4 dropped, o_overflow=1.
  - i_clr_status pulse gives 0.
- Mid-frame window change: change x0 from 0 to 3 during line 2.
  - Expect the current frame unaffected; the next frame starts at col 3.
- Reset during href: assert i_rst_n=0 mid-line.
  - Expect all outputs 0 and no output until a full vsync rise/fall cycle.
- Partial pixel: href falls after an odd byte count (BPP=2, 5 bytes).
  - Expect 2 pixels, col_max=2, the trailing byte discarded.

Source files
------------

// File: rtl/camera_capture_window_if.sv
// Pixel stream leaving the camera capture front-end: valid/ready handshake with
// start-of-frame and end-of-line sideband.
interface camera_capture_window_if #(
    parameter int PIX_W = 16
);
    logic             valid;
    logic [PIX_W-1:0] data;
    logic             sof;
    logic             eol;
    logic             ready;

    modport master (
        output valid,
        output data,
        output sof,
        output eol,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  sof,
        input  eol,
        output ready
    );
endinterface

// File: rtl/camera_capture_window.sv
// DVP camera capture front-end: pixel assembly, crop window, power-of-two decimation
// and an output FIFO. Define CAPTURE_TESTPATTERN_EN to add the i_tp_sel row/col test pattern.
module camera_capture_window #(
    parameter int DATA_W     = 8,
    parameter int BPP        = 2,
    parameter int COL_W      = 11,
    parameter int ROW_W      = 10,
    parameter int FIFO_DEPTH = 16,
    parameter int DEC_W      = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_vsync,
    input  logic              i_href,
    input  logic [DATA_W-1:0] i_data,
    input  logic [COL_W-1:0]  i_win_x0,
    input  logic [ROW_W-1:0]  i_win_y0,
    input  logic [COL_W-1:0]  i_win_w,
    input  logic [ROW_W-1:0]  i_win_h,
    input  logic [DEC_W-1:0]  i_decim_log2,
    input  logic              i_clr_status,
`ifdef CAPTURE_TESTPATTERN_EN
    input  logic              i_tp_sel,
`endif
    camera_capture_window_if.master pix,
    output logic [ROW_W-1:0]  o_row_max,
    output logic [COL_W-1:0]  o_col_max,
    output logic [7:0]        o_frame_cnt,
    output logic              o_overflow
);

    localparam int PIX_W = DATA_W * BPP;
    localparam int PH_W  = (BPP > 1) ? $clog2(BPP) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int ENT_W = PIX_W + 2;
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(BPP - 1);
    localparam logic [COL_W:0]  COL_ONE  = (COL_W + 1)'(1);
    localparam logic [ROW_W:0]  ROW_ONE  = (ROW_W + 1)'(1);
    localparam logic [AW:0]     FIFO_MAX = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        DISARMED,
        SYNC_WAIT,
        CAPTURE
    } state_t;

    state_t state;
    state_t state_next;

    logic              vs_r;
    logic              vs_q;
    logic              hr_r;
    logic              hr_q;
    logic [DATA_W-1:0] d_r;
    logic              vs_rise;
    logic              vs_fall;
    logic              hr_fall;

    logic [COL_W-1:0]  x0_sh;
    logic [ROW_W-1:0]  y0_sh;
    logic [COL_W-1:0]  w_sh;
    logic [ROW_W-1:0]  h_sh;
    logic [DEC_W-1:0]  dec_sh;
    logic              en_sh;

    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [PH_W-1:0]   phase;
    logic [PIX_W-1:0]  shift_buf;
    logic [PIX_W-1:0]  assembled;
    logic [PIX_W-1:0]  px_word;
    logic              sof_pend;
    logic              byte_ok;
    logic              pix_done;

    logic [COL_W:0]    col_ext;
    logic [COL_W:0]    x_lo;
    logic [COL_W:0]    x_hi;
    logic [COL_W:0]    col_step;
    logic [COL_W:0]    col_mask;
    logic [ROW_W:0]    row_ext;
    logic [ROW_W:0]    y_lo;
    logic [ROW_W:0]    y_hi;
    logic [ROW_W:0]    row_step;
    logic [ROW_W:0]    row_mask;
    logic              in_x;
    logic              in_y;
    logic              x_ok;
    logic              y_ok;
    logic              keep;
    logic              eol_hit;

    logic              px_valid;
    logic [PIX_W-1:0]  px_data;
    logic              px_sof;
    logic              px_eol;

    logic [ENT_W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [ENT_W-1:0]  head;
    logic              fifo_valid;
    logic              fifo_full;
    logic              pop;
    logic              push_ok;
    logic              drop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vs_r <= 1'b0;
            vs_q <= 1'b0;
            hr_r <= 1'b0;
            hr_q <= 1'b0;
            d_r  <= '0;
        end else begin
            vs_r <= i_vsync;
            vs_q <= vs_r;
            hr_r <= i_href;
            hr_q <= hr_r;
            d_r  <= i_data;
        end
    end

    assign vs_rise = vs_r & ~vs_q;
    assign vs_fall = ~vs_r & vs_q;
    assign hr_fall = ~hr_r & hr_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= DISARMED;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            DISARMED:  if (vs_rise) state_next = SYNC_WAIT;
            SYNC_WAIT: if (vs_fall && en_sh) state_next = CAPTURE;
            CAPTURE:   if (vs_rise) state_next = SYNC_WAIT;
            default:   state_next = DISARMED;
        endcase
    end

    // Bytes shift in MSB-first; the oldest leftover bits fall off the top.
    assign byte_ok   = (state == CAPTURE) && hr_r && !vs_rise;
    assign pix_done  = byte_ok && (phase == PH_LAST);
    assign assembled = (shift_buf << DATA_W) | PIX_W'(d_r);

`ifdef CAPTURE_TESTPATTERN_EN
    assign px_word = i_tp_sel ? PIX_W'({(PIX_W / 2)'(row), (PIX_W / 2)'(col)}) : assembled;
`else
    assign px_word = assembled;
`endif

    // Window bounds are one bit wider than the counters so x0+w never wraps.
    always_comb begin
        col_ext  = {1'b0, col};
        x_lo     = {1'b0, x0_sh};
        x_hi     = x_lo + {1'b0, w_sh};
        col_step = COL_ONE << dec_sh;
        col_mask = col_step - COL_ONE;
        row_ext  = {1'b0, row};
        y_lo     = {1'b0, y0_sh};
        y_hi     = y_lo + {1'b0, h_sh};
        row_step = ROW_ONE << dec_sh;
        row_mask = row_step - ROW_ONE;
        in_x     = (col_ext >= x_lo) && (col_ext < x_hi);
        in_y     = (row_ext >= y_lo) && (row_ext < y_hi);
        x_ok     = ((col_ext - x_lo) & col_mask) == '0;
        y_ok     = ((row_ext - y_lo) & row_mask) == '0;
        keep     = in_x && in_y && x_ok && y_ok;
        eol_hit  = (col_ext + col_step) >= x_hi;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            row         <= '0;
            col         <= '0;
            phase       <= '0;
            shift_buf   <= '0;
            sof_pend    <= 1'b0;
            x0_sh       <= '0;
            y0_sh       <= '0;
            w_sh        <= '0;
            h_sh        <= '0;
            dec_sh      <= '0;
            en_sh       <= 1'b0;
            o_row_max   <= '0;
            o_col_max   <= '0;
            o_frame_cnt <= '0;
        end else begin
            if (byte_ok) begin
                shift_buf <= assembled;
                if (phase == PH_LAST) begin
                    phase <= '0;
                    if (col != '1) begin
                        col <= col + COL_W'(1);
                    end
                end else begin
                    phase <= phase + PH_W'(1);
                end
            end
            if (hr_fall) begin
                phase <= '0;
                if (col != '0) begin
                    o_col_max <= col;
                    col       <= '0;
                    if (row != '1) begin
                        row <= row + ROW_W'(1);
                    end
                end
            end
            if (pix_done && keep) begin
                sof_pend <= 1'b0;
            end
            // Frame boundary: settings are frozen here for the whole next frame.
            if (vs_rise && state != DISARMED) begin
                o_row_max <= row;
                if (state == CAPTURE) begin
                    o_frame_cnt <= o_frame_cnt + 8'd1;
                end
                row      <= '0;
                col      <= '0;
                phase    <= '0;
                sof_pend <= 1'b1;
                x0_sh    <= i_win_x0;
                y0_sh    <= i_win_y0;
                w_sh     <= i_win_w;
                h_sh     <= i_win_h;
                dec_sh   <= i_decim_log2;
                en_sh    <= i_enable;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            px_valid <= 1'b0;
            px_data  <= '0;
            px_sof   <= 1'b0;
            px_eol   <= 1'b0;
        end else begin
            px_valid <= pix_done && keep;
            px_data  <= px_word;
            px_sof   <= sof_pend;
            px_eol   <= eol_hit;
        end
    end

    assign fifo_valid = (count != '0);
    assign fifo_full  = (count == FIFO_MAX);
    assign pop        = fifo_valid && pix.ready;
    assign push_ok    = px_valid && (!fifo_full || pop);
    assign drop       = px_valid && fifo_full && !pop;

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {px_sof, px_eol, px_data};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (push_ok ? COL_ONE[AW:0] : '0) - (pop ? COL_ONE[AW:0] : '0);
            if (drop) begin
                o_overflow <= 1'b1;
            end else if (i_clr_status) begin
                o_overflow <= 1'b0;
            end
        end
    end

    // Head entry is masked so every output reads zero while the FIFO is empty.
    assign head      = mem[rd_ptr];
    assign pix.valid = fifo_valid;
    assign pix.data  = fifo_valid ? head[PIX_W-1:0] : '0;
    assign pix.sof   = fifo_valid & head[PIX_W+1];
    assign pix.eol   = fifo_valid & head[PIX_W];

endmodule

// File: tb/tb_camera_capture_window.sv
// Randomised directed bench for camera_capture_window with a frame-level reference model
// and an output scoreboard.
module tb_camera_capture_window;

    localparam int DATA_W     = 8;
    localparam int BPP        = 2;
    localparam int COL_W      = 11;
    localparam int ROW_W      = 10;
    localparam int FIFO_DEPTH = 16;
    localparam int DEC_W      = 2;
    localparam int PIX_W      = DATA_W * BPP;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable;
    logic              vsync;
    logic              href;
    logic [DATA_W-1:0] data;
    logic [COL_W-1:0]  win_x0;
    logic [ROW_W-1:0]  win_y0;
    logic [COL_W-1:0]  win_w;
    logic [ROW_W-1:0]  win_h;
    logic [DEC_W-1:0]  decim_log2;
    logic              clr_status;
    logic [ROW_W-1:0]  row_max;
    logic [COL_W-1:0]  col_max;
    logic [7:0]        frame_cnt;
    logic              overflow;

    camera_capture_window_if #(.PIX_W(PIX_W)) pix_if ();

    camera_capture_window #(
        .DATA_W(DATA_W), .BPP(BPP), .COL_W(COL_W), .ROW_W(ROW_W),
        .FIFO_DEPTH(FIFO_DEPTH), .DEC_W(DEC_W)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_enable(enable),
        .i_vsync(vsync),
        .i_href(href),
        .i_data(data),
        .i_win_x0(win_x0),
        .i_win_y0(win_y0),
        .i_win_w(win_w),
        .i_win_h(win_h),
        .i_decim_log2(decim_log2),
        .i_clr_status(clr_status),
`ifdef CAPTURE_TESTPATTERN_EN
        .i_tp_sel(1'b0),
`endif
        .pix(pix_if),
        .o_row_max(row_max),
        .o_col_max(col_max),
        .o_frame_cnt(frame_cnt),
        .o_overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PIX_W-1:0] data;
        bit               sof;
        bit               eol;
    } exp_pix_t;

    exp_pix_t exp_q[$];
    int compared   = 0;
    int mismatched = 0;
    int rx_count   = 0;
    int base;
    bit ready_random = 1'b0;

    // Reference model: frame-level view of what the capture block should emit.
    bit m_armed, m_en_sh, m_capturing, m_sof_pend, m_stall;
    int m_x0, m_y0, m_w, m_h, m_n;
    int m_row, m_row_max, m_col_max, m_frame_cnt, m_stall_pushed;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_pix_t e;
        if (rst_n && pix_if.valid && pix_if.ready) begin
            rx_count++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected pixel", pix_if.valid, 0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("pixel data", pix_if.data, e.data);
                checkOutput("pixel sof", pix_if.sof, e.sof);
                checkOutput("pixel eol", pix_if.eol, e.eol);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (ready_random) pix_if.ready = ($urandom_range(0, 7) != 0);
    endtask

    task automatic applyStimulus(input logic [DATA_W-1:0] b);
        href = 1'b1;
        data = b;
        tick();
    endtask

    task automatic idle(input int n);
        href = 1'b0;
        repeat (n) tick();
    endtask

    function automatic bit m_keep(input int c, input int r);
        int step = 1 << m_n;
        if (c < m_x0 || c >= m_x0 + m_w) return 1'b0;
        if (r < m_y0 || r >= m_y0 + m_h) return 1'b0;
        return ((c - m_x0) % step == 0) && ((r - m_y0) % step == 0);
    endfunction

    task automatic model_push(input logic [PIX_W-1:0] w, input bit eol);
        exp_pix_t e;
        e.data = w;
        e.sof  = m_sof_pend;
        e.eol  = eol;
        m_sof_pend = 1'b0;
        if (!m_stall) begin
            exp_q.push_back(e);
        end else if (m_stall_pushed < FIFO_DEPTH) begin
            exp_q.push_back(e);
            m_stall_pushed++;
        end
    endtask

    task automatic sendLine(input int n_pix, input int extra);
        logic [PIX_W-1:0]  word;
        logic [DATA_W-1:0] b;
        for (int c = 0; c < n_pix; c++) begin
            word = '0;
            for (int k = 0; k < BPP; k++) begin
                b = DATA_W'($urandom);
                word = {word[PIX_W-DATA_W-1:0], b};
                applyStimulus(b);
            end
            if (m_capturing && m_keep(c, m_row)) model_push(word, (c + (1 << m_n)) >= (m_x0 + m_w));
        end
        for (int k = 0; k < extra; k++) applyStimulus(DATA_W'($urandom));
        idle(6);
        if (m_capturing && n_pix > 0) begin
            m_col_max = n_pix;
            m_row++;
        end
    endtask

    task automatic sendFrame(input int rows, input int n_pix);
        for (int r = 0; r < rows; r++) sendLine(n_pix, 0);
    endtask

    task automatic setWindow(input int x0, input int y0, input int w, input int h, input int n);
        win_x0     = COL_W'(x0);
        win_y0     = ROW_W'(y0);
        win_w      = COL_W'(w);
        win_h      = ROW_W'(h);
        decim_log2 = DEC_W'(n);
    endtask

    task automatic vsyncPulse();
        if (!m_armed) begin
            m_armed = 1'b1;
        end else begin
            m_row_max = m_row;
            if (m_capturing) m_frame_cnt = (m_frame_cnt + 1) % 256;
            m_capturing = 1'b0;
            m_row       = 0;
            m_sof_pend  = 1'b1;
            m_x0 = int'(win_x0);
            m_y0 = int'(win_y0);
            m_w  = int'(win_w);
            m_h  = int'(win_h);
            m_n  = int'(decim_log2);
            m_en_sh = enable;
        end
        href  = 1'b0;
        vsync = 1'b1;
        repeat (4) tick();
        vsync = 1'b0;
        repeat (4) tick();
        m_capturing = m_en_sh;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        exp_q.delete();
        m_armed = 0; m_en_sh = 0; m_capturing = 0; m_sof_pend = 0; m_stall = 0;
        m_x0 = 0; m_y0 = 0; m_w = 0; m_h = 0; m_n = 0;
        m_row = 0; m_row_max = 0; m_col_max = 0; m_frame_cnt = 0; m_stall_pushed = 0;
        repeat (3) tick();
        checkOutput("reset valid", pix_if.valid, 0);
        checkOutput("reset data", pix_if.data, 0);
        checkOutput("reset sof", pix_if.sof, 0);
        checkOutput("reset eol", pix_if.eol, 0);
        checkOutput("reset row_max", row_max, 0);
        checkOutput("reset col_max", col_max, 0);
        checkOutput("reset frame_cnt", frame_cnt, 0);
        checkOutput("reset overflow", overflow, 0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic waitDrain();
        int budget = 400;
        while ((exp_q.size() != 0 || pix_if.valid) && budget > 0) begin
            tick();
            budget--;
        end
        checkOutput("drain leftover", exp_q.size(), 0);
    endtask

    initial begin
        enable = 1'b1; vsync = 1'b0; href = 1'b0; data = '0; clr_status = 1'b0;
        pix_if.ready = 1'b1;
        setWindow(0, 0, 8, 4, 0);
        doReset();

        // Full window, two frames
        vsyncPulse();
        vsyncPulse();
        base = rx_count;
        sendFrame(4, 8);
        vsyncPulse();
        waitDrain();
        checkOutput("frame1 pixel count", rx_count - base, 32);
        checkOutput("frame1 frame_cnt", frame_cnt, 1);
        checkOutput("frame1 row_max", row_max, 4);
        checkOutput("frame1 col_max", col_max, 8);
        sendFrame(4, 8);
        setWindow(2, 1, 4, 2, 1);
        vsyncPulse();
        waitDrain();
        checkOutput("frame2 frame_cnt", frame_cnt, 2);

        // Crop plus decimation
        base = rx_count;
        sendFrame(4, 8);
        vsyncPulse();
        waitDrain();
        checkOutput("crop pixel count", rx_count - base, 2);
        checkOutput("crop row_max", row_max, 4);

        // Random windows, frame sizes and downstream stalls
        ready_random = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sendFrame($urandom_range(2, 5), $urandom_range(1, 10));
            setWindow($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 10),
                      $urandom_range(0, 5), $urandom_range(0, 3));
            vsyncPulse();
        end
        waitDrain();
        ready_random = 1'b0;
        pix_if.ready = 1'b1;
        checkOutput("random frame_cnt", frame_cnt, m_frame_cnt);
        checkOutput("random row_max", row_max, m_row_max);
        checkOutput("random col_max", col_max, m_col_max);
        checkOutput("random overflow", overflow, 0);

        // Mid-frame window change only takes effect next frame
        sendFrame(3, 6);
        setWindow(0, 0, 8, 4, 0);
        vsyncPulse();
        base = rx_count;
        sendLine(8, 0);
        sendLine(8, 0);
        setWindow(3, 0, 8, 4, 0);
        sendLine(8, 0);
        sendLine(8, 0);
        vsyncPulse();
        waitDrain();
        checkOutput("midchange frame count", rx_count - base, 32);
        base = rx_count;
        sendFrame(4, 8);
        setWindow(0, 0, 32, 4, 0);
        vsyncPulse();
        waitDrain();
        checkOutput("shifted frame count", rx_count - base, 20);

        // Backpressure: 20-pixel line into a 16-entry FIFO
        pix_if.ready = 1'b0;
        m_stall = 1'b1;
        m_stall_pushed = 0;
        base = rx_count;
        sendLine(20, 0);
        checkOutput("stall overflow", overflow, 1);
        checkOutput("stall valid", pix_if.valid, 1);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        tick();
        checkOutput("overflow cleared", overflow, 0);
        m_stall = 1'b0;
        pix_if.ready = 1'b1;
        waitDrain();
        checkOutput("stall retained count", rx_count - base, FIFO_DEPTH);
        sendFrame(3, 8);
        setWindow(0, 0, 8, 4, 0);
        vsyncPulse();
        waitDrain();

        // Partial pixel: five bytes give two pixels
        base = rx_count;
        sendLine(2, 1);
        checkOutput("partial col_max", col_max, 2);
        sendFrame(3, 8);
        vsyncPulse();
        waitDrain();
        checkOutput("partial frame count", rx_count - base, 26);
        checkOutput("partial row_max", row_max, 4);

        // Reset in the middle of an active line
        sendLine(8, 0);
        for (int k = 0; k < 3; k++) applyStimulus(DATA_W'($urandom));
        doReset();
        base = rx_count;
        for (int k = 0; k < 5; k++) applyStimulus(DATA_W'($urandom));
        idle(6);
        sendLine(8, 0);
        vsyncPulse();
        sendFrame(4, 8);
        checkOutput("post-reset silence", rx_count - base, 0);
        vsyncPulse();
        sendFrame(4, 8);
        vsyncPulse();
        waitDrain();
        checkOutput("post-reset frame count", rx_count - base, 32);
        checkOutput("post-reset frame_cnt", frame_cnt, 1);
        checkOutput("final overflow", overflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
